// File: rtl/cycle_sequencer_if.sv
// cycle_sequencer_if: memory bus handshake between the sequencer (master) and memory (slave).
interface cycle_sequencer_if;
  logic       Bus_Ack;
  logic [7:0] Bus_Data;
  logic       Bus_Req;
  logic       Bus_WE;
  logic       Bus_M1;
  modport master (output Bus_Req, Bus_WE, Bus_M1, input Bus_Ack, Bus_Data);
  modport slave  (input Bus_Req, Bus_WE, Bus_M1, output Bus_Ack, Bus_Data);
endinterface

// File: rtl/cycle_sequencer.sv
// cycle_sequencer: FETCH/EXEC/MREAD/MWRITE opcode sequencer with XPT step counter and ITABLE.
// Optional bus wait timeout enabled by defining SEQ_WAIT_TIMEOUT_EN.
module cycle_sequencer (
  input  logic                     CLK,
  input  logic                     notReset,
  cycle_sequencer_if.master        bus,
  input  logic                     P2_Set_CM1,
  input  logic                     P2_Reset_ITABLE,
  input  logic                     PR_Reset_XPT,
  input  logic                     P2_Set_CMR,
  input  logic                     Seq_Write,
  input  logic                     ITABLE_Load,
  input  logic [7:0]               ITABLE_In,
  output logic [3:0]               XPT,
  output logic [3:0]               notXPT,
  output logic [7:0]               ITABLE,
  output logic [7:0]               notITABLE,
  output logic [7:0]               OP,
  output logic                     OP7,
  output logic                     notOP7,
  output logic                     Dec_Enable,
  output logic                     Seq_Error
);
  typedef enum logic [1:0] {FETCH, EXEC, MREAD, MWRITE} state_t;
  state_t     state_q, state_d;
  logic [3:0] xpt_q, xpt_d;
  logic [7:0] itable_q, itable_d, op_q, op_d;
  logic       err_q, err_d, run_q, run_d;
  logic       busy, abort;
  // run_q keeps bus strobes low during reset and for one cycle after a timeout abort
  assign busy = run_q && state_q != EXEC;
`ifdef SEQ_WAIT_TIMEOUT_EN
  logic [3:0] wait_q, wait_d;
  assign wait_d = (busy && !bus.Bus_Ack) ? wait_q + 4'd1 : 4'd0;
  assign abort  = busy && !bus.Bus_Ack && wait_q == 4'd15;
  always_ff @(posedge CLK) wait_q <= !notReset ? 4'd0 : wait_d;
`else
  assign abort = 1'b0;
`endif
  always_comb begin
    state_d  = state_q;
    xpt_d    = xpt_q;
    itable_d = itable_q;
    op_d     = op_q;
    err_d    = err_q;
    run_d    = !abort;
    if (abort) begin
      state_d  = FETCH;
      itable_d = 8'h00;
      err_d    = 1'b1;
    end else begin
      case (state_q)
        FETCH: if (run_q && bus.Bus_Ack) begin
          op_d    = bus.Bus_Data;
          xpt_d   = 4'd0;
          state_d = EXEC;
        end
        EXEC: begin
          itable_d = ITABLE_Load ? ITABLE_In : (P2_Reset_ITABLE && P2_Set_CM1) ? 8'h00 : itable_q;
          if (P2_Set_CM1) begin
            state_d = FETCH;
            xpt_d   = 4'd0;
          end else if (P2_Set_CMR) begin
            state_d = MREAD;
            err_d   = err_q | Seq_Write;
          end else if (Seq_Write) begin
            state_d = MWRITE;
          end else if (PR_Reset_XPT) begin
            xpt_d = 4'd0;
          end else begin
            xpt_d = xpt_q + 4'd1;
            err_d = err_q | (&xpt_q);
          end
        end
        default: if (run_q && bus.Bus_Ack) begin
          state_d = EXEC;
          xpt_d   = xpt_q + 4'd1;
          err_d   = err_q | (&xpt_q);
        end
      endcase
    end
  end
  always_ff @(posedge CLK) begin
    if (!notReset) begin
      state_q  <= FETCH;
      xpt_q    <= 4'd0;
      itable_q <= 8'h00;
      op_q     <= 8'h00;
      err_q    <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      xpt_q    <= xpt_d;
      itable_q <= itable_d;
      op_q     <= op_d;
      err_q    <= err_d;
      run_q    <= run_d;
    end
  end
  assign bus.Bus_Req = busy;
  assign bus.Bus_WE  = run_q && state_q == MWRITE;
  assign bus.Bus_M1  = run_q && state_q == FETCH;
  assign Dec_Enable  = state_q == EXEC;
  assign XPT         = xpt_q;
  assign notXPT      = ~xpt_q;
  assign ITABLE      = itable_q;
  assign notITABLE   = ~itable_q;
  assign OP          = op_q;
  assign OP7         = op_q[7];
  assign notOP7      = ~op_q[7];
  assign Seq_Error   = err_q;
endmodule

// File: tb/tb_cycle_sequencer.sv
// tb_cycle_sequencer: directed checks of fetch, execute, bus cycles, ITABLE, wrap and reset.
module tb_cycle_sequencer;
  logic       CLK = 1'b0;
  logic       notReset, P2_Set_CM1, P2_Reset_ITABLE, PR_Reset_XPT, P2_Set_CMR, Seq_Write, ITABLE_Load;
  logic [7:0] ITABLE_In, ITABLE, notITABLE, OP;
  logic [3:0] XPT, notXPT;
  logic       OP7, notOP7, Dec_Enable, Seq_Error;
  int         total = 0, passed = 0;
  cycle_sequencer_if bus_if();
  cycle_sequencer dut (
    .CLK(CLK), .notReset(notReset), .bus(bus_if),
    .P2_Set_CM1(P2_Set_CM1), .P2_Reset_ITABLE(P2_Reset_ITABLE), .PR_Reset_XPT(PR_Reset_XPT),
    .P2_Set_CMR(P2_Set_CMR), .Seq_Write(Seq_Write), .ITABLE_Load(ITABLE_Load), .ITABLE_In(ITABLE_In),
    .XPT(XPT), .notXPT(notXPT), .ITABLE(ITABLE), .notITABLE(notITABLE), .OP(OP), .OP7(OP7),
    .notOP7(notOP7), .Dec_Enable(Dec_Enable), .Seq_Error(Seq_Error)
  );
  always #5 CLK = ~CLK;
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic fetch(input logic [7:0] d);
    bus_if.Bus_Ack = 1'b1;
    bus_if.Bus_Data = d;
    tick();
    bus_if.Bus_Ack = 1'b0;
  endtask
  initial begin
    notReset = 0; P2_Set_CM1 = 0; P2_Reset_ITABLE = 0; PR_Reset_XPT = 0; P2_Set_CMR = 0;
    Seq_Write = 0; ITABLE_Load = 0; ITABLE_In = 0; bus_if.Bus_Ack = 0; bus_if.Bus_Data = 0;
    tick(); tick();
    chk("rst_req", {7'd0, bus_if.Bus_Req}, 8'd0);
    chk("rst_dec", {7'd0, Dec_Enable}, 8'd0);
    chk("rst_xpt", {4'd0, XPT}, 8'd0);
    chk("rst_nxpt", {4'd0, notXPT}, 8'h0F);
    chk("rst_itable", ITABLE, 8'h00);
    chk("rst_op", OP, 8'h00);
    chk("rst_err", {7'd0, Seq_Error}, 8'd0);
    notReset = 1;
    tick();
    chk("fetch_req", {7'd0, bus_if.Bus_Req}, 8'd1);
    chk("fetch_m1", {7'd0, bus_if.Bus_M1}, 8'd1);
    chk("fetch_we", {7'd0, bus_if.Bus_WE}, 8'd0);
    fetch(8'h8A);
    chk("op", OP, 8'h8A);
    chk("op7", {7'd0, OP7}, 8'd1);
    chk("nop7", {7'd0, notOP7}, 8'd0);
    chk("exec_dec", {7'd0, Dec_Enable}, 8'd1);
    chk("exec_xpt0", {4'd0, XPT}, 8'd0);
    chk("exec_req", {7'd0, bus_if.Bus_Req}, 8'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("idle_xpt", {4'd0, XPT}, 8'(i));
    end
    P2_Set_CMR = 1;
    tick();
    P2_Set_CMR = 0;
    for (int i = 0; i < 3; i++) begin
      chk("mread_req", {7'd0, bus_if.Bus_Req}, 8'd1);
      chk("mread_we", {7'd0, bus_if.Bus_WE}, 8'd0);
      chk("mread_xpt", {4'd0, XPT}, 8'd3);
      if (i == 2) bus_if.Bus_Ack = 1;
      tick();
    end
    bus_if.Bus_Ack = 0;
    chk("mread_done_req", {7'd0, bus_if.Bus_Req}, 8'd0);
    chk("mread_done_xpt", {4'd0, XPT}, 8'd4);
    chk("mread_done_dec", {7'd0, Dec_Enable}, 8'd1);
    ITABLE_Load = 1; ITABLE_In = 8'h25;
    tick();
    ITABLE_Load = 0;
    chk("itable_load", ITABLE, 8'h25);
    chk("nitable", notITABLE, 8'hDA);
    P2_Set_CM1 = 1; P2_Reset_ITABLE = 1; Seq_Write = 1;
    tick();
    P2_Set_CM1 = 0; P2_Reset_ITABLE = 0; Seq_Write = 0;
    chk("cm1_itable", ITABLE, 8'h00);
    chk("cm1_m1", {7'd0, bus_if.Bus_M1}, 8'd1);
    chk("cm1_we", {7'd0, bus_if.Bus_WE}, 8'd0);
    chk("cm1_xpt", {4'd0, XPT}, 8'd0);
    fetch(8'h12);
    chk("op2", OP, 8'h12);
    chk("op2_nop7", {7'd0, notOP7}, 8'd1);
    P2_Set_CM1 = 1; P2_Reset_ITABLE = 1; ITABLE_Load = 1; ITABLE_In = 8'h31;
    tick();
    P2_Set_CM1 = 0; P2_Reset_ITABLE = 0; ITABLE_Load = 0;
    chk("load_wins", ITABLE, 8'h31);
    fetch(8'h00);
    P2_Reset_ITABLE = 1;
    tick();
    P2_Reset_ITABLE = 0;
    chk("rst_itable_alone", ITABLE, 8'h31);
    chk("rst_itable_xpt", {4'd0, XPT}, 8'd1);
    PR_Reset_XPT = 1;
    tick();
    PR_Reset_XPT = 0;
    chk("pr_reset_xpt", {4'd0, XPT}, 8'd0);
    bus_if.Bus_Ack = 1;
    tick();
    bus_if.Bus_Ack = 0;
    chk("ack_in_exec_dec", {7'd0, Dec_Enable}, 8'd1);
    chk("ack_in_exec_xpt", {4'd0, XPT}, 8'd1);
    P2_Set_CMR = 1; Seq_Write = 1;
    tick();
    P2_Set_CMR = 0; Seq_Write = 0;
    chk("cmr_wr_req", {7'd0, bus_if.Bus_Req}, 8'd1);
    chk("cmr_wr_we", {7'd0, bus_if.Bus_WE}, 8'd0);
    chk("cmr_wr_err", {7'd0, Seq_Error}, 8'd1);
    notReset = 0;
    tick();
    notReset = 1;
    chk("err_cleared", {7'd0, Seq_Error}, 8'd0);
    tick();
    fetch(8'h40);
    for (int i = 1; i <= 15; i++) tick();
    chk("xpt15", {4'd0, XPT}, 8'd15);
    chk("xpt15_err", {7'd0, Seq_Error}, 8'd0);
    tick();
    chk("wrap_xpt", {4'd0, XPT}, 8'd0);
    chk("wrap_nxpt", {4'd0, notXPT}, 8'h0F);
    chk("wrap_err", {7'd0, Seq_Error}, 8'd1);
    Seq_Write = 1; ITABLE_Load = 1; ITABLE_In = 8'h5A;
    tick();
    Seq_Write = 0; ITABLE_Load = 0;
    chk("mwrite_req", {7'd0, bus_if.Bus_Req}, 8'd1);
    chk("mwrite_we", {7'd0, bus_if.Bus_WE}, 8'd1);
    chk("mwrite_itable", ITABLE, 8'h5A);
    chk("mwrite_xpt", {4'd0, XPT}, 8'd0);
    notReset = 0;
    tick();
    chk("midrst_req", {7'd0, bus_if.Bus_Req}, 8'd0);
    chk("midrst_we", {7'd0, bus_if.Bus_WE}, 8'd0);
    chk("midrst_itable", ITABLE, 8'h00);
    chk("midrst_err", {7'd0, Seq_Error}, 8'd0);
    chk("midrst_dec", {7'd0, Dec_Enable}, 8'd0);
    notReset = 1;
    tick();
    fetch(8'h01);
    P2_Set_CMR = 1;
    tick();
    P2_Set_CMR = 0;
`ifdef SEQ_WAIT_TIMEOUT_EN
    for (int i = 0; i < 15; i++) tick();
    chk("to_wait_req", {7'd0, bus_if.Bus_Req}, 8'd1);
    chk("to_wait_err", {7'd0, Seq_Error}, 8'd0);
    tick();
    chk("to_abort_req", {7'd0, bus_if.Bus_Req}, 8'd0);
    chk("to_abort_err", {7'd0, Seq_Error}, 8'd1);
    chk("to_abort_dec", {7'd0, Dec_Enable}, 8'd0);
    tick();
    chk("to_refetch_m1", {7'd0, bus_if.Bus_M1}, 8'd1);
`else
    for (int i = 0; i < 40; i++) tick();
    chk("nowait_req", {7'd0, bus_if.Bus_Req}, 8'd1);
    chk("nowait_err", {7'd0, Seq_Error}, 8'd0);
    chk("nowait_xpt", {4'd0, XPT}, 8'd0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 SHALL have ports: CLK  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: notReset  in  1  synchronous, active-low reset.
REQ-003 SHALL have ports: Bus_Ack  in  1  memory cycle completion; Bus_Data  in  8  fetched opcode.
REQ-004 SHALL have ports: P2_Set_CM1, P2_Reset_ITABLE, PR_Reset_XPT, P2_Set_CMR (read request), Seq_Write (write request), ITABLE_Load  in  1 each, decoder strobes; ITABLE_In  in  8  next ITABLE value.
REQ-005 SHALL have ports: XPT/notXPT  out  4  step counter and complement; ITABLE/notITABLE  out  8  table register and complement; OP  out  8  latched opcode; OP7/notOP7  out  1  OP[7] and complement.
REQ-006 SHALL have ports: Dec_Enable  out  1  decoder enable; Bus_Req, Bus_WE, Bus_M1  out  1  bus cycle request, write, opcode-fetch marker; Seq_Error  out  1  sticky fault.

Function
REQ-007 SHALL implement four states: FETCH, EXEC, MREAD, MWRITE.
REQ-008 FETCH SHALL drive Bus_Req=1, Bus_M1=1, Bus_WE=0; on Bus_Ack=1, OP<=Bus_Data, XPT<=0, next state EXEC.
REQ-009 EXEC SHALL drive Dec_Enable=1 and Bus_Req=0; Dec_Enable SHALL be 0 in every other state.
REQ-010 In EXEC, strobes SHALL be evaluated at the clock edge with priority P2_Set_CM1 > P2_Set_CMR > Seq_Write > PR_Reset_XPT > default.
REQ-011 P2_Set_CM1: next state FETCH, XPT<=0; Seq_Write and P2_Set_CMR are ignored that cycle.
REQ-012 P2_Set_CMR: next state MREAD, XPT held; Seq_Write concurrently asserted SHALL be dropped and Seq_Error set.
REQ-013 Seq_Write alone: next state MWRITE, XPT held.
REQ-014 PR_Reset_XPT alone: XPT<=0, stay EXEC; default: XPT<=XPT+1.
REQ-015 XPT=15 with increment SHALL wrap to 0 and set Seq_Error.
REQ-016 MREAD SHALL drive Bus_Req=1, Bus_WE=0, Bus_M1=0; MWRITE SHALL drive Bus_Req=1, Bus_WE=1, Bus_M1=0; on Bus_Ack=1 both SHALL return to EXEC with XPT<=XPT+1.
REQ-017 Bus_Req SHALL remain asserted and outputs stable until Bus_Ack; Bus_Ack outside FETCH/MREAD/MWRITE SHALL be ignored.
REQ-018 ITABLE SHALL update only in EXEC: ITABLE_Load -> ITABLE_In; else P2_Reset_ITABLE with P2_Set_CM1 -> 0; Load wins when both assert.
REQ-019 P2_Reset_ITABLE without P2_Set_CM1 SHALL have no effect.
REQ-020 notXPT, notITABLE, notOP7 SHALL always be the exact bitwise complements of their true outputs.
REQ-021 All outputs SHALL be registered or decoded from registered state only; no combinational path from inputs to outputs.

Reset
REQ-022 notReset=0 at an edge SHALL force, in any state including mid-bus-cycle: state FETCH, XPT=0, ITABLE=0, OP=0, Seq_Error=0, wait counter=0.
REQ-023 While notReset=0, Bus_Req, Bus_WE, Bus_M1 and Dec_Enable SHALL be 0; first edge with notReset=1 enters FETCH with Bus_Req=1.

Configuration
REQ-024 Macro SEQ_WAIT_TIMEOUT_EN defined: 4-bit wait counter counts cycles in FETCH/MREAD/MWRITE without Bus_Ack, clears on state entry; 16th waiting cycle aborts: Bus_Req=0 next cycle, state FETCH, ITABLE<=0, Seq_Error<=1.
REQ-025 Macro SEQ_WAIT_TIMEOUT_EN undefined: no counter; bus cycles wait indefinitely; Seq_Error set only per REQ-012/015.

Verification
REQ-026 Reset release, Bus_Ack=1 next cycle with Bus_Data=0x8A -> OP=0x8A, OP7=1, notOP7=0, state EXEC, XPT=0, Dec_Enable=1.
REQ-027 EXEC, 3 idle cycles then P2_Set_CMR, Bus_Ack after 2 waits -> XPT 0,1,2,3 held 3 cycles, then 4; Bus_Req high exactly 3 cycles, Bus_WE=0.
REQ-028 EXEC, P2_Set_CM1+P2_Reset_ITABLE+Seq_Write same edge with ITABLE=0x25 -> FETCH, ITABLE=0x00, no MWRITE; with ITABLE_Load=1, ITABLE_In=0x31 -> ITABLE=0x31.
REQ-029 EXEC, 16 idle increments from XPT=0 -> XPT=15 then 0, Seq_Error=1; P2_Set_CMR+Seq_Write together -> MREAD, Seq_Error=1.
REQ-030 notReset=0 during MWRITE with Bus_Req=1 -> next edge Bus_Req=0, XPT=0, ITABLE=0, Seq_Error=0.
REQ-031 SEQ_WAIT_TIMEOUT_EN defined, MREAD without Bus_Ack 16 cycles -> Bus_Req=0, FETCH, Seq_Error=1; undefined -> Bus_Req stays 1 after 40 cycles.
